// File: rtl/mgmt_sram_pkg.sv
// Purpose: shared types and constants for the management-SoC SRAM Wishbone bridge.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mgmt_sram_pkg;

  // Data path geometry of the SRAM macro
  localparam int RAM_DW = 32;
  localparam int RAM_BW = RAM_DW / 8;

  // Default placement of the RAM window in the management address map
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0100_0000;

  // Access sequencer states; the four hit states fit in two bits, ERR needs the third
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_CAPT  = 3'd2,
    ST_ACK   = 3'd3,
    ST_ERR   = 3'd4
  } sram_st_t;

  // Active-low byte write enables: reads keep every lane disabled
  function automatic logic [RAM_BW-1:0] wen_lanes(input logic we, input logic [RAM_BW-1:0] sel);
    return we ? ~sel : {RAM_BW{1'b1}};
  endfunction

endpackage

// File: rtl/wb_sram_512x32_ctrl.sv
// Purpose: Wishbone classic slave turning each cycle into one registered SRAM access, err on window miss.
// Latency: request at edge N -> ack sampled at edge N+3 (read and write); err sampled at edge N+2.
// Backpressure: one access in flight; next request accepted only back in IDLE (<= 1 access per 4 cycles).
module wb_sram_512x32_ctrl
  import mgmt_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          WORDS     = 512,
  parameter int          AW        = 9
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [RAM_BW-1:0] wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [RAM_DW-1:0] wbs_dat_i,
  output logic              wbs_ack_o,
  output logic              wbs_err_o,
  output logic [RAM_DW-1:0] wbs_dat_o,
  output logic              ram_cen,
  output logic              ram_gwen,
  output logic [RAM_BW-1:0] ram_wen,
  output logic [AW-1:0]     ram_a,
  output logic [RAM_DW-1:0] ram_d,
  input  logic [RAM_DW-1:0] ram_q
);

  // Window is aligned to its own size, so a hit is an equality on the bits above the word index
  localparam int WIN_LSB = AW + 2;

  sram_st_t state;
  logic     rd_op;    // current access is a read, so CAPT must load ram_q
  logic     aborted;  // master dropped cyc while the RAM access was in flight
  logic     req;
  logic     hit;
  logic     unused_adr_lsb;

  // Byte offset within a word carries no meaning for a 32-bit only slave
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // A request is only new once the previous response pulse has been consumed
  assign req = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & ~wbs_err_o;
  assign hit = (wbs_adr_i[31:WIN_LSB] == BASE_ADDR[31:WIN_LSB]);

  // Sequencer: FSM, RAM strobes and WB response are all registered here
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state     <= ST_IDLE;
      rd_op     <= 1'b0;
      aborted   <= 1'b0;
      ram_cen   <= 1'b1;
      ram_gwen  <= 1'b1;
      ram_wen   <= {RAM_BW{1'b1}};
      ram_a     <= '0;
      ram_d     <= '0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          wbs_ack_o <= 1'b0;
          wbs_err_o <= 1'b0;
          if (req) begin
            if (hit) begin
              ram_a    <= wbs_adr_i[AW+1:2];
              ram_d    <= wbs_dat_i;
              ram_cen  <= 1'b0;
              ram_gwen <= ~wbs_we_i;
              ram_wen  <= wen_lanes(wbs_we_i, wbs_sel_i);
              rd_op    <= ~wbs_we_i;
              aborted  <= 1'b0;
              state    <= ST_ISSUE;
            end else begin
              // Miss: the RAM is never touched
              state <= ST_ERR;
            end
          end
        end

        ST_ISSUE: begin
          // The RAM samples the strobes on this edge; release them for every later cycle
          ram_cen  <= 1'b1;
          ram_gwen <= 1'b1;
          ram_wen  <= {RAM_BW{1'b1}};
          if (!wbs_cyc_i) begin
            aborted <= 1'b1;
          end
          state <= ST_CAPT;
        end

        ST_CAPT: begin
          // Writes leave the previous read data visible
          if (rd_op) begin
            wbs_dat_o <= ram_q;
          end
          wbs_ack_o <= wbs_cyc_i & ~aborted;
          state     <= ST_ACK;
        end

        ST_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= ST_IDLE;
        end

        ST_ERR: begin
          // Cleared again by IDLE on the following edge
          wbs_err_o <= 1'b1;
          state     <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The RAM is enabled for exactly one cycle per accepted hit
  cen_single_cycle: assert property (@(posedge wb_clk_i) disable iff (!wb_rstn_i)
    !ram_cen |=> ram_cen);

  // A cycle terminates with either ack or err, never both
  ack_err_exclusive: assert property (@(posedge wb_clk_i) disable iff (!wb_rstn_i)
    !(wbs_ack_o && wbs_err_o));

endmodule

// File: tb/tb_wb_sram_512x32_ctrl.sv
module tb_wb_sram_512x32_ctrl;

  localparam logic [31:0] B = 32'h0100_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rstn_i;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o, wbs_err_o;
  logic [31:0] wbs_dat_o;
  logic        ram_cen, ram_gwen;
  logic [3:0]  ram_wen;
  logic [8:0]  ram_a;
  logic [31:0] ram_d, ram_q;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_sram_512x32_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .wb_rstn_i(wb_rstn_i),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_err_o(wbs_err_o),
    .wbs_dat_o(wbs_dat_o),
    .ram_cen  (ram_cen),
    .ram_gwen (ram_gwen),
    .ram_wen  (ram_wen),
    .ram_a    (ram_a),
    .ram_d    (ram_d),
    .ram_q    (ram_q)
  );

  // Behavioural 512x32 byte-writable SRAM macro
  logic [31:0] mem [512];
  always @(posedge wb_clk_i) begin
    if (!ram_cen) begin
      if (!ram_gwen) begin
        for (int b = 0; b < 4; b++)
          if (!ram_wen[b]) mem[ram_a][8*b +: 8] <= ram_d[8*b +: 8];
      end else begin
        ram_q <= mem[ram_a];
      end
    end
  end

  int cnt = 0;
  always @(posedge wb_clk_i) cnt <= cnt + 1;

  typedef struct {bit is_err; bit chk_dat; logic [31:0] dat; int due;} resp_t;
  typedef struct {logic [8:0] a; bit gwen; logic [3:0] wen; logic [31:0] d; int due;} acc_t;
  resp_t rq[$];
  acc_t  aq[$];
  resp_t me;
  acc_t  ma;

  int n_chk = 0;
  int n_pass = 0;
  int ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: pops expectations whenever the DUT responds or strobes the RAM
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o) ack_cnt++;
    if (wbs_ack_o || wbs_err_o) begin
      if (rq.size() == 0) begin
        chk("unexpected_resp", {30'b0, wbs_err_o, wbs_ack_o}, 32'h0);
      end else begin
        me = rq.pop_front();
        chk("resp_err", {31'b0, wbs_err_o}, {31'b0, me.is_err});
        chk("resp_ack", {31'b0, wbs_ack_o}, {31'b0, !me.is_err});
        chk("resp_cycle", cnt, me.due);
        if (me.chk_dat) chk("rd_data", wbs_dat_o, me.dat);
      end
    end
    if (!ram_cen) begin
      if (aq.size() == 0) begin
        chk("unexpected_ram_access", {31'b0, ram_cen}, 32'h1);
      end else begin
        ma = aq.pop_front();
        chk("ram_a", {23'b0, ram_a}, {23'b0, ma.a});
        chk("ram_gwen", {31'b0, ram_gwen}, {31'b0, ma.gwen});
        chk("ram_wen", {28'b0, ram_wen}, {28'b0, ma.wen});
        chk("ram_cycle", cnt, ma.due);
        if (!ma.gwen) chk("ram_d", ram_d, ma.d);
      end
    end
  end

  task automatic drive(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_sel_i = sel;  wbs_dat_i = dat;
  endtask

  task automatic idle_bus();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic push_acc(input int k, input bit we, input logic [31:0] adr,
                          input logic [3:0] wen, input logic [31:0] dat);
    acc_t a;
    a = '{adr[10:2], !we, wen, dat, k + 1};
    aq.push_back(a);
  endtask

  // One complete WB cycle; exp_wen is the hand-derived RAM byte-enable pattern
  task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input logic [3:0] exp_wen,
                      input bit exp_err, input logic [31:0] exp_rd);
    resp_t r;
    int    k;
    bit    got;
    @(posedge wb_clk_i); #1;
    drive(we, adr, sel, dat);
    k = cnt;
    if (exp_err) begin
      r = '{1'b1, 1'b0, 32'h0, k + 2};
    end else begin
      r = '{1'b0, !we, exp_rd, k + 3};
      push_acc(k, we, adr, exp_wen, dat);
    end
    rq.push_back(r);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o || wbs_err_o) got = 1'b1;
    end
    chk("resp_timeout", {31'b0, got}, 32'h1);
    @(posedge wb_clk_i); #1;
    idle_bus();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cen"},  {31'b0, ram_cen},  32'h1);
    chk({tag, "_gwen"}, {31'b0, ram_gwen}, 32'h1);
    chk({tag, "_wen"},  {28'b0, ram_wen},  32'hF);
    chk({tag, "_a"},    {23'b0, ram_a},    32'h0);
    chk({tag, "_d"},    ram_d,             32'h0);
    chk({tag, "_ack"},  {31'b0, wbs_ack_o}, 32'h0);
    chk({tag, "_err"},  {31'b0, wbs_err_o}, 32'h0);
    chk({tag, "_dat"},  wbs_dat_o,         32'h0);
  endtask

  initial begin
    int k;
    int saved;
    wb_rstn_i = 1'b0;
    idle_bus();
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    #12;
    chk_reset_vals("por");
    @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);

    // Full-word write then read of word 4
    xfer(1'b1, B + 32'h10, 4'hF, 32'hDEADBEEF, 4'h0, 1'b0, 32'h0);
    xfer(1'b0, B + 32'h10, 4'hF, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF);
    // Single byte lane 2 write merges into the stored word
    xfer(1'b1, B + 32'h10, 4'b0100, 32'h00AA0000, 4'hB, 1'b0, 32'h0);
    xfer(1'b0, B + 32'h10, 4'hF, 32'h0,        4'hF, 1'b0, 32'hDEAABEEF);
    // Just above and just below the window
    xfer(1'b0, B + 32'h800, 4'hF, 32'h0, 4'hF, 1'b1, 32'h0);
    xfer(1'b0, B - 32'h4,   4'hF, 32'h0, 4'hF, 1'b1, 32'h0);
    // Last word, then first address past it
    xfer(1'b1, B + 32'h7FC, 4'hF, 32'hCAFEF00D, 4'h0, 1'b0, 32'h0);
    xfer(1'b0, B + 32'h7FC, 4'hF, 32'h0,        4'hF, 1'b0, 32'hCAFEF00D);
    xfer(1'b1, B + 32'h800, 4'hF, 32'h11111111, 4'hF, 1'b1, 32'h0);
    // Write with no lanes selected still strobes the RAM but changes nothing
    xfer(1'b1, B + 32'h10, 4'h0, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, B + 32'h10, 4'hF, 32'h0,        4'hF, 1'b0, 32'hDEAABEEF);

    // Master abort during ISSUE: write commits, no ack
    @(posedge wb_clk_i); #1;
    drive(1'b1, B + 32'h1C, 4'hF, 32'h12345678);
    k = cnt;
    push_acc(k, 1'b1, B + 32'h1C, 4'h0, 32'h12345678);
    saved = ack_cnt;
    @(posedge wb_clk_i); #1;
    idle_bus();
    repeat (6) @(negedge wb_clk_i);
    chk("abort_no_ack", ack_cnt, saved);
    xfer(1'b0, B + 32'h1C, 4'hF, 32'h0, 4'hF, 1'b0, 32'h12345678);

    // Reset asserted while the read sits in CAPT
    @(posedge wb_clk_i); #1;
    drive(1'b0, B + 32'h7FC, 4'hF, 32'h5555AAAA);
    k = cnt;
    push_acc(k, 1'b0, B + 32'h7FC, 4'hF, 32'h5555AAAA);
    repeat (2) @(posedge wb_clk_i);
    #2;
    wb_rstn_i = 1'b0;
    #1;
    chk_reset_vals("midrst");
    idle_bus();
    repeat (2) @(negedge wb_clk_i);
    wb_rstn_i = 1'b1;
    xfer(1'b0, B + 32'h7FC, 4'hF, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D);

    repeat (5) @(negedge wb_clk_i);
    chk("resp_queue_drained", rq.size(), 32'h0);
    chk("acc_queue_drained",  aq.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
